shift_sequencer: RTL and testbench

Command-driven controller that sits directly upstream of the one-bit shift register cells. It accepts one shift/load/hold command per handshake and expands it into a cycle-by-cycle stream of `sel` codes and serial fill bits. These outputs drive all WIDTH cells of the chain in parallel. The block reports completion with a single-cycle `done` pulse.

---
 rtl/shift_sequencer.sv | 175 +++++++++++++++++
 tb/tb_shift_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : shift_sequencer
// Description : Expands one hold/shift/load command per handshake into a
//               cycle-by-cycle stream of cell select codes and serial fill
//               bits for a WIDTH-cell shift chain, then pulses done.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             sync_reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             cmd_fill,
    output logic [1:0]       sel,
    output logic             rightshift,
    output logic             leftshift,
    output logic             busy,
    output logic             done
);

    // State encoding
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    // Cell select encoding
    localparam logic [1:0] c_OP_HOLD  = 2'b00;
    localparam logic [1:0] c_OP_LEFT  = 2'b01;
    localparam logic [1:0] c_OP_RIGHT = 2'b10;
    localparam logic [1:0] c_OP_LOAD  = 2'b11;

    // Saturation limit expressed in counter width
    localparam logic [CNT_W-1:0] c_WIDTH_CNT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] c_ONE_CNT   = CNT_W'(1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [1:0]       r_op;
    logic [1:0]       w_op_nxt;
    logic             r_fill;
    logic             w_fill_nxt;

    logic [CNT_W-1:0] w_n;
    logic             w_accept;

    logic [1:0]       r_sel;
    logic             r_rightshift;
    logic             r_leftshift;
    logic             r_busy;
    logic             r_done;
    logic [1:0]       w_sel_nxt;
    logic             w_rightshift_nxt;
    logic             w_leftshift_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;

    // Ready depends on state only, never on cmd_valid
    assign cmd_ready = (r_state == c_ST_IDLE);
    assign w_accept  = cmd_valid && cmd_ready;

    // Active cycle count for the presented command: load is a single cycle,
    // everything else saturates at the chain length
    always_comb begin
        w_n = cmd_count;
        if (cmd_op == c_OP_LOAD) begin
            w_n = c_ONE_CNT;
        end else if (cmd_count > c_WIDTH_CNT) begin
            w_n = c_WIDTH_CNT;
        end
    end

    // State register plus latched command fields
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
            r_op    <= c_OP_HOLD;
            r_fill  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_op    <= w_op_nxt;
            r_fill  <= w_fill_nxt;
        end
    end

    // Next-state logic: accept in IDLE, count down in RUN, one DONE cycle
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_op_nxt    = r_op;
        w_fill_nxt  = r_fill;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept) begin
                    w_op_nxt    = cmd_op;
                    w_fill_nxt  = cmd_fill;
                    w_cnt_nxt   = w_n;
                    w_state_nxt = (w_n == '0) ? c_ST_DONE : c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                w_cnt_nxt = r_cnt - c_ONE_CNT;
                if (r_cnt <= c_ONE_CNT) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so the registered outputs line up
    // with the state they belong to
    always_comb begin
        w_sel_nxt        = c_OP_HOLD;
        w_rightshift_nxt = 1'b0;
        w_leftshift_nxt  = 1'b0;
        w_busy_nxt       = 1'b0;
        w_done_nxt       = 1'b0;
        case (w_state_nxt)
            c_ST_RUN: begin
                w_sel_nxt        = w_op_nxt;
                w_rightshift_nxt = (w_op_nxt == c_OP_RIGHT) && w_fill_nxt;
                w_leftshift_nxt  = (w_op_nxt == c_OP_LEFT) && w_fill_nxt;
                w_busy_nxt       = 1'b1;
            end
            c_ST_DONE: begin
                w_busy_nxt = 1'b1;
                w_done_nxt = 1'b1;
            end
            default: begin
                w_busy_nxt = 1'b0;
            end
        endcase
    end

    // Output registers; the serial bit and select code change on the same edge
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            r_sel        <= c_OP_HOLD;
            r_rightshift <= 1'b0;
            r_leftshift  <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_sel        <= w_sel_nxt;
            r_rightshift <= w_rightshift_nxt;
            r_leftshift  <= w_leftshift_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
        end
    end

    assign sel        = r_sel;
    assign rightshift = r_rightshift;
    assign leftshift  = r_leftshift;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_sequencer
// Description : Self-checking bench for shift_sequencer. A transaction-level
//               model turns each accepted command into a queue of expected
//               per-cycle outputs; directed cases plus random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_sequencer;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk;
    logic             sync_reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_count;
    logic             cmd_fill;
    logic [1:0]       sel;
    logic             rightshift;
    logic             leftshift;
    logic             busy;
    logic             done;

    int n_checks = 0;
    int n_errors = 0;

    shift_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_dut (
        .clk        (clk),
        .sync_reset (sync_reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_count  (cmd_count),
        .cmd_fill   (cmd_fill),
        .sel        (sel),
        .rightshift (rightshift),
        .leftshift  (leftshift),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs for one cycle
    typedef struct packed {
        logic [1:0] sel;
        logic       rs;
        logic       ls;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t q_exp[$];
    exp_t cur = '0;

    // Reference model: each accepted command becomes n active cycles then a
    // done cycle; an empty schedule with a non-busy current cycle means idle
    always @(posedge clk) begin
        int   n;
        exp_t e;
        if (sync_reset) begin
            q_exp.delete();
            cur = '0;
        end else if (q_exp.size() > 0) begin
            cur = q_exp.pop_front();
        end else if (cur.busy) begin
            cur = '0;
        end else if (cmd_valid) begin
            if (cmd_op == 2'b11)          n = 1;
            else if (cmd_count > WIDTH)   n = WIDTH;
            else                          n = int'(cmd_count);
            for (int i = 0; i < n; i++) begin
                e.sel  = cmd_op;
                e.rs   = (cmd_op == 2'b10) && cmd_fill;
                e.ls   = (cmd_op == 2'b01) && cmd_fill;
                e.busy = 1'b1;
                e.done = 1'b0;
                q_exp.push_back(e);
            end
            e = '0;
            e.busy = 1'b1;
            e.done = 1'b1;
            q_exp.push_back(e);
            cur = q_exp.pop_front();
        end else begin
            cur = '0;
        end
    end

    // Downstream 8-cell chain driven by the sequencer outputs (MSB first)
    logic [WIDTH-1:0] cells = '0;
    logic             cell_clr = 1'b0;
    always @(posedge clk) begin
        if (cell_clr) cells = '0;
        else begin
            case (sel)
                2'b01:   cells = {cells[WIDTH-2:0], leftshift};
                2'b10:   cells = {rightshift, cells[WIDTH-1:1]};
                2'b11:   cells = '0;
                default: cells = cells;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Compare all outputs against the model for the current cycle
    task automatic check_outputs();
        check("cmd_ready", 32'(cmd_ready), 32'(!cur.busy));
        check("sel",       32'(sel),       32'(cur.sel));
        check("rightshift",32'(rightshift),32'(cur.rs));
        check("leftshift", 32'(leftshift), 32'(cur.ls));
        check("busy",      32'(busy),      32'(cur.busy));
        check("done",      32'(done),      32'(cur.done));
    endtask

    // One cycle: check what the last edge produced, then drive next inputs
    task automatic step(input logic rst, input logic v, input logic [1:0] op,
                        input logic [CNT_W-1:0] cnt, input logic fill);
        @(negedge clk);
        check_outputs();
        sync_reset = rst;
        cmd_valid  = v;
        cmd_op     = op;
        cmd_count  = cnt;
        cmd_fill   = fill;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 2'b00, '0, 1'b0);
    endtask

    initial begin
        sync_reset = 1'b1;
        cmd_valid  = 1'b1;
        cmd_op     = 2'b11;
        cmd_count  = 4'd5;
        cmd_fill   = 1'b0;

        // Reset held two cycles with a command presented
        step(1'b1, 1'b1, 2'b11, 4'd5, 1'b0);
        step(1'b0, 1'b0, 2'b00, 4'd0, 1'b0);
        check("reset_ready", 32'(cmd_ready), 32'd1);
        check("reset_busy",  32'(busy),      32'd0);

        // Load ignores count: one cycle of 11 then done
        step(1'b0, 1'b1, 2'b11, 4'd5, 1'b0);
        idle(4);

        // Right shift of three ones into a cleared chain
        cell_clr = 1'b1;
        idle(1);
        cell_clr = 1'b0;
        step(1'b0, 1'b1, 2'b10, 4'd3, 1'b1);
        idle(6);
        check("chain_after_rshift", 32'(cells), 32'h0000_00E0);

        // Saturation: count 12 yields WIDTH left shifts
        step(1'b0, 1'b1, 2'b01, 4'd12, 1'b0);
        idle(11);

        // Zero count goes straight to done
        step(1'b0, 1'b1, 2'b10, 4'd0, 1'b1);
        idle(3);

        // Abort with a held second command during RUN
        step(1'b0, 1'b1, 2'b10, 4'd6, 1'b1);
        step(1'b0, 1'b1, 2'b01, 4'd2, 1'b1);
        step(1'b0, 1'b1, 2'b01, 4'd2, 1'b1);
        step(1'b1, 1'b1, 2'b01, 4'd2, 1'b1);
        step(1'b0, 1'b1, 2'b01, 4'd2, 1'b1);
        idle(5);

        // Random traffic including occasional resets
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 2) != 0),
                 2'($urandom_range(0, 3)),
                 CNT_W'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)));
        end
        idle(12);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
